uart_tx_arbiter: RTL and testbench

Shares the single uart_tx transmitter among NUM_REQ byte sources, e.g. button event character, RX acknowledge 'R', and status/trigger reports. It picks requesters round-robin, latches the winning byte and pulses tx_start. It then tracks tx_busy through rise and fall before granting again. It sits in top between the control logic and uart_tx, replacing the direct tx_start/tx_data drive.

---
 rtl/uart_ctrl_pkg.sv | 26 ++
 rtl/rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 113 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART control slice: arbiter state encoding,
// ASCII report characters and a constant-foldable clog2.
package uart_ctrl_pkg;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] START     = 2'd1;
    localparam logic [1:0] WAIT_BUSY = 2'd2;
    localparam logic [1:0] WAIT_DONE = 2'd3;

    localparam logic [7:0] ASCII_E = 8'h45;
    localparam logic [7:0] ASCII_R = 8'h52;
    localparam logic [7:0] ASCII_A = 8'h41;
    localparam logic [7:0] ASCII_B = 8'h42;
    localparam logic [7:0] ASCII_C = 8'h43;
    localparam logic [7:0] ASCII_D = 8'h44;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after the
// pointer, wrapping modulo NUM_REQ (also correct for non-power-of-2 counts).
module rr_pick
    import uart_ctrl_pkg::*;
#(
    parameter int  NUM_REQ = 4,
    localparam int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [ID_W-1:0]    o_grant,
    output logic               o_any_valid
);

    always_comb begin
        int best_off;
        int off;
        o_grant     = '0;
        o_any_valid = |i_req_valid;
        best_off    = NUM_REQ;
        off         = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            // Distance of requester j from the pointer, going forward with wrap.
            off = j - int'(i_rr_ptr);
            if (off < 0) begin
                off = off + NUM_REQ;
            end
            if (i_req_valid[j] && (off < best_off)) begin
                best_off = off;
                o_grant  = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte sources; it
// waits for tx_busy to rise and fall before granting again.
module uart_tx_arbiter
    import uart_ctrl_pkg::*;
#(
    parameter int  NUM_REQ      = 4,
    parameter int  BUSY_TIMEOUT = 16,
    localparam int ID_W         = clog2(NUM_REQ)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      active_id,
    output logic                 arb_busy,
    output logic                 timeout_err
);

    localparam int TIMER_W = clog2(BUSY_TIMEOUT) + 1;

    logic [1:0]         r_state;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [TIMER_W-1:0] r_timer;
    logic [NUM_REQ-1:0] r_req_ack;
    logic               r_tx_start;
    logic [7:0]         r_tx_data;
    logic [ID_W-1:0]    r_active_id;
    logic               r_arb_busy;
    logic               r_timeout_err;

    logic [1:0]      w_state_next;
    logic [ID_W-1:0] w_grant;
    logic [ID_W-1:0] w_rr_next;
    logic            w_any_valid;
    logic            w_grant_ok;
    logic            w_timeout_hit;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req_valid (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_any_valid (w_any_valid)
    );

    assign w_grant_ok    = (r_state == IDLE) && w_any_valid && !tx_busy;
    assign w_timeout_hit = (r_timer == TIMER_W'(BUSY_TIMEOUT - 1));
    assign w_rr_next     = (w_grant == ID_W'(NUM_REQ - 1)) ? '0 : w_grant + ID_W'(1);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:      if (w_grant_ok) w_state_next = START;
            START:     w_state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_next = WAIT_DONE;
                end else if (w_timeout_hit) begin
                    w_state_next = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) w_state_next = IDLE;
            default:   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state       <= IDLE;
            r_rr_ptr      <= '0;
            r_timer       <= '0;
            r_req_ack     <= '0;
            r_tx_start    <= 1'b0;
            r_tx_data     <= 8'h00;
            r_active_id   <= '0;
            r_arb_busy    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_arb_busy <= (w_state_next != IDLE);
            r_tx_start <= (r_state == START);
            r_req_ack  <= '0;
            if (w_grant_ok) begin
                r_req_ack   <= NUM_REQ'(1) << w_grant;
                r_tx_data   <= req_data[{w_grant, 3'b000} +: 8];
                r_active_id <= w_grant;
                r_rr_ptr    <= w_rr_next;
            end
            if (r_state == START) begin
                r_timer <= '0;
            end else if ((r_state == WAIT_BUSY) && !tx_busy && !w_timeout_hit) begin
                r_timer <= r_timer + TIMER_W'(1);
            end
            // The dropped byte is not retried; only the sticky flag records it.
            if ((r_state == WAIT_BUSY) && !tx_busy && w_timeout_hit) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign req_ack     = r_req_ack;
    assign tx_start    = r_tx_start;
    assign tx_data     = r_tx_data;
    assign active_id   = r_active_id;
    assign arb_busy    = r_arb_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timestamp-based transfer model checked every
// cycle, a reactive uart_tx busy responder, and directed scenarios.
module tb_uart_tx_arbiter;
    import uart_ctrl_pkg::*;

    localparam int NR = 4;
    localparam int TO = 16;

    logic        sys_clk   = 1'b0;
    logic        sys_rst   = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic        tx_busy   = 1'b0;
    logic [3:0]  req_ack;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [1:0]  active_id;
    logic        arb_busy;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rq_data [NR][8];
    int         rq_n    [NR];
    int         rq_pos  [NR];

    int bdur          = 3;
    bit busy_force_en = 1'b0;
    bit busy_force_v  = 1'b0;
    int busy_cnt      = 0;
    int busy_fall_cyc = 0;

    int         obs_id[$];
    logic [7:0] obs_data[$];
    int nstart    = 0;
    int ack_cyc   = 0;
    int start_cyc = 0;
    int idle_cyc  = 0;
    int err_cyc   = 0;

    uart_tx_arbiter #(
        .NUM_REQ      (NR),
        .BUSY_TIMEOUT (TO)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .active_id   (active_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    initial forever #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Model: a transfer starts at grant; tx_start two cycles after the sampling
    // cycle; busy must be seen within TO cycles of tx_start, then must fall.
    initial begin : model
        logic [3:0]  v;
        logic [31:0] d;
        logic        b, r;
        logic [3:0]  exp_ack;
        int c, g, idx;
        bit m_idle, m_err, prev_busy, prev_err;
        int m_ptr, m_id, m_start, m_rise;
        logic [7:0] m_data;
        m_idle = 1'b1; m_err = 1'b0; m_ptr = 0; m_id = 0; m_start = -100; m_rise = -1;
        m_data = 8'h00; prev_busy = 1'b0; prev_err = 1'b0;
        forever begin
            @(posedge sys_clk);
            v = req_valid; d = req_data; b = tx_busy; r = sys_rst;
            c = cyc;
            cyc = c + 1;
            #1;
            exp_ack = '0;
            if (r) begin
                m_idle = 1'b1; m_err = 1'b0; m_ptr = 0; m_id = 0; m_data = 8'h00;
                m_start = -100; m_rise = -1;
            end else if (m_idle) begin
                if (v != 4'b0000 && !b) begin
                    g = -1;
                    for (int k = 0; k < NR; k++) begin
                        idx = (m_ptr + k) % NR;
                        if (g < 0 && v[idx]) g = idx;
                    end
                    exp_ack = 4'(1 << g);
                    m_data  = d[8*g +: 8];
                    m_id    = g;
                    m_ptr   = (g + 1) % NR;
                    m_idle  = 1'b0;
                    m_start = c + 2;
                    m_rise  = -1;
                end
            end else if (c >= m_start) begin
                if (m_rise < 0) begin
                    if (b) begin
                        m_rise = c;
                    end else if (c == m_start + TO - 1) begin
                        m_idle = 1'b1;
                        m_err  = 1'b1;
                    end
                end else if (!b) begin
                    m_idle = 1'b1;
                end
            end
            chk("req_ack", req_ack, exp_ack);
            chk("tx_start", tx_start, (!r && (c + 1 == m_start)) ? 1 : 0);
            chk("tx_data", tx_data, m_data);
            chk("active_id", active_id, m_id);
            chk("arb_busy", arb_busy, m_idle ? 0 : 1);
            chk("timeout_err", timeout_err, m_err);
            if (req_ack != 4'b0000) begin
                for (int k = 0; k < NR; k++) if (req_ack[k]) obs_id.push_back(k);
                obs_data.push_back(tx_data);
                ack_cyc = cyc;
            end
            if (tx_start) begin
                nstart++;
                start_cyc = cyc;
            end
            if (prev_busy && !arb_busy) idle_cyc = cyc;
            if (timeout_err && !prev_err) err_cyc = cyc;
            prev_busy = arb_busy;
            prev_err  = timeout_err;
        end
    end

    // Requesters hold each byte until acked; uart_tx stand-in raises busy the
    // cycle after tx_start for bdur cycles unless forced.
    initial begin : drive
        logic nb;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) busy_cnt = 0;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ack[i]) rq_pos[i]++;
                if (rq_pos[i] < rq_n[i]) begin
                    req_valid[i]        = 1'b1;
                    req_data[8*i +: 8]  = rq_data[i][rq_pos[i]];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            if (busy_force_en) begin
                nb = busy_force_v;
            end else if (tx_start) begin
                busy_cnt = bdur;
                nb = 1'b0;
            end else if (busy_cnt > 0) begin
                nb = 1'b1;
                busy_cnt--;
            end else begin
                nb = 1'b0;
            end
            if (tx_busy && !nb) busy_fall_cyc = cyc;
            tx_busy = nb;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge sys_clk);
            #2;
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        for (int i = 0; i < NR; i++) begin
            rq_n[i]   = 0;
            rq_pos[i] = 0;
        end
        busy_force_en = 1'b0;
        obs_id.delete();
        obs_data.delete();
        nstart = 0;
        tick(2);
        sys_rst = 1'b0;
    endtask

    task automatic add_byte(input int i, input logic [7:0] b);
        rq_data[i][rq_n[i]] = b;
        rq_n[i]++;
    endtask

    task automatic wait_grants(input string name, input int n, input int max);
        int k;
        k = 0;
        while (obs_id.size() < n && k < max) begin
            tick(1);
            k++;
        end
        chk(name, obs_id.size(), n);
    endtask

    task automatic wait_idle(input string name, input int max);
        int k;
        k = 0;
        while (arb_busy && k < max) begin
            tick(1);
            k++;
        end
        chk(name, arb_busy, 0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] bytes_t2 [NR];
        int         ids_t3   [5];
        bytes_t2 = '{ASCII_A, ASCII_B, ASCII_C, ASCII_D};
        ids_t3   = '{0, 3, 0, 3, 0};
        for (int i = 0; i < NR; i++) begin
            rq_n[i]   = 0;
            rq_pos[i] = 0;
        end
        tick(3);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_arb_busy", arb_busy, 0);
        chk("rst_req_ack", req_ack, 0);
        sys_rst = 1'b0;
        tick(2);

        // Single requester with a long busy window.
        do_reset();
        bdur = 20;
        add_byte(2, ASCII_R);
        wait_grants("t1_grant", 1, 10);
        wait_idle("t1_idle", 40);
        chk("t1_id", obs_id[0], 2);
        chk("t1_data", obs_data[0], 8'h52);
        chk("t1_nstart", nstart, 1);
        chk("t1_active_id", active_id, 2);
        chk("t1_start_lat", start_cyc - ack_cyc, 1);
        chk("t1_idle_lat", idle_cyc - ack_cyc, 23);

        // All four requesters at once.
        do_reset();
        bdur = 3;
        for (int i = 0; i < NR; i++) add_byte(i, bytes_t2[i]);
        wait_grants("t2_grants", 4, 60);
        wait_idle("t2_idle", 20);
        for (int i = 0; i < NR; i++) begin
            chk("t2_id", obs_id[i], i);
            chk("t2_data", obs_data[i], 8'h41 + i);
        end
        chk("t2_nstart", nstart, 4);

        // Persistent requester 0 against requester 3.
        do_reset();
        add_byte(0, ASCII_A); add_byte(0, ASCII_B); add_byte(0, ASCII_C);
        add_byte(3, ASCII_D); add_byte(3, ASCII_E);
        wait_grants("t3_grants", 5, 80);
        wait_idle("t3_idle", 20);
        for (int i = 0; i < 5; i++) chk("t3_id", obs_id[i], ids_t3[i]);

        // Busy never rises: timeout, then a normal transfer.
        do_reset();
        busy_force_en = 1'b1;
        busy_force_v  = 1'b0;
        add_byte(1, ASCII_E);
        wait_grants("t4_grant", 1, 10);
        wait_idle("t4_idle", 40);
        chk("t4_err", timeout_err, 1);
        chk("t4_err_lat", err_cyc - start_cyc, 16);
        busy_force_en = 1'b0;
        add_byte(2, ASCII_R);
        wait_grants("t4_grant2", 2, 10);
        wait_idle("t4_idle2", 20);
        chk("t4_id2", obs_id[1], 2);
        chk("t4_data2", obs_data[1], 8'h52);
        chk("t4_err_sticky", timeout_err, 1);

        // Busy held high in IDLE blocks grants.
        do_reset();
        busy_force_en = 1'b1;
        busy_force_v  = 1'b1;
        add_byte(0, ASCII_A);
        tick(10);
        chk("t5_no_ack", obs_id.size(), 0);
        chk("t5_no_start", nstart, 0);
        busy_force_en = 1'b0;
        wait_grants("t5_grant", 1, 10);
        chk("t5_grant_lat", ack_cyc - busy_fall_cyc, 1);
        wait_idle("t5_idle", 20);

        // Reset during WAIT_DONE.
        do_reset();
        bdur = 20;
        add_byte(2, ASCII_A); add_byte(2, ASCII_B); add_byte(3, ASCII_C);
        wait_grants("t6_grant", 1, 10);
        chk("t6_first_id", obs_id[0], 2);
        tick(4);
        chk("t6_pre_busy", arb_busy, 1);
        sys_rst = 1'b1;
        #1;
        chk("t6_rst_tx_start", tx_start, 0);
        chk("t6_rst_tx_data", tx_data, 8'h00);
        chk("t6_rst_req_ack", req_ack, 0);
        chk("t6_rst_active_id", active_id, 0);
        chk("t6_rst_arb_busy", arb_busy, 0);
        chk("t6_rst_timeout_err", timeout_err, 0);
        obs_id.delete();
        obs_data.delete();
        tick(2);
        sys_rst = 1'b0;
        wait_grants("t6_regrant", 1, 10);
        chk("t6_after_id", obs_id[0], 2);
        chk("t6_after_data", obs_data[0], ASCII_B);
        wait_grants("t6_drain", 2, 60);
        wait_idle("t6_idle", 40);
        chk("t6_last_id", obs_id[1], 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
